// File: rtl/rx_phy_pkg.sv
// Shared receive-PHY definitions: alignment symbols, default word width and the
// serial-to-parallel FSM state encoding.
package rx_phy_pkg;

  localparam int unsigned S2P_WIDTH    = 32;
  localparam logic [7:0]  S2P_COM_BYTE = 8'hBC;
  localparam logic [7:0]  S2P_IDL_BYTE = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } s2p_state_t;

endpackage : rx_phy_pkg

// File: rtl/rx_word_classifier.sv
// Combinational word classifier: flags a word made entirely of COM or IDL bytes.
// Zero latency; no flow control.
module rx_word_classifier
  import rx_phy_pkg::*;
#(
  parameter int unsigned WIDTH    = S2P_WIDTH,
  parameter logic [7:0]  COM_BYTE = S2P_COM_BYTE,
  parameter logic [7:0]  IDL_BYTE = S2P_IDL_BYTE
) (
  input  logic [WIDTH-1:0] nsr,
  output logic             is_com,
  output logic             is_idl
);

  localparam logic [WIDTH-1:0] COM_W = {WIDTH/8{COM_BYTE}};
  localparam logic [WIDTH-1:0] IDL_W = {WIDTH/8{IDL_BYTE}};

  assign is_com = (nsr == COM_W);
  assign is_idl = (nsr == IDL_W);

endmodule : rx_word_classifier

// File: rtl/rx_serial_to_parallel.sv
// Serial-to-parallel receive stage: COM-aligns an MSB-first bit stream and emits 32-bit words,
// updated on the edge of each word's last bit; no backpressure, output held for a full word period.
module rx_serial_to_parallel
  import rx_phy_pkg::*;
#(
  parameter int unsigned WIDTH    = S2P_WIDTH,
  parameter logic [7:0]  COM_BYTE = S2P_COM_BYTE,
  parameter logic [7:0]  IDL_BYTE = S2P_IDL_BYTE,
  parameter int unsigned NUM_COM  = 4
) (
  input  logic             clk_S2P,
  input  logic             reset,
  input  logic             data_in_S2P,
  output logic [WIDTH-1:0] data_out_S2P,
  output logic             valid_out_S2P,
  output logic             active_out_S2P
);

  localparam int unsigned CNT_W     = $clog2(WIDTH);
  localparam int unsigned COM_CNT_W = $clog2(NUM_COM + 1);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [COM_CNT_W-1:0] COM_LAST = COM_CNT_W'(NUM_COM);

  s2p_state_t            state, state_nxt;
  // Only the low WIDTH-1 history bits are ever reused, so the oldest bit is not stored.
  logic [WIDTH-2:0]      sr;
  logic [WIDTH-1:0]      nsr;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [COM_CNT_W-1:0]  com_cnt, com_cnt_nxt;
  logic [WIDTH-1:0]      data_nxt;
  logic                  valid_nxt;
  logic                  active_nxt;
  logic                  boundary;
  logic                  is_com;
  logic                  is_idl;

  assign nsr      = {sr, data_in_S2P};
  assign boundary = (bit_cnt == BIT_LAST);

  rx_word_classifier #(
    .WIDTH    (WIDTH),
    .COM_BYTE (COM_BYTE),
    .IDL_BYTE (IDL_BYTE)
  ) u_classifier (
    .nsr    (nsr),
    .is_com (is_com),
    .is_idl (is_idl)
  );

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_out_S2P;
    valid_nxt   = valid_out_S2P;
    active_nxt  = active_out_S2P;

    case (state)
      SEARCH: begin
        // The first COM match fixes the word phase for the rest of the session.
        if (is_com) begin
          bit_cnt_nxt = '0;
          if (NUM_COM == 1) begin
            state_nxt   = ACTIVE;
            active_nxt  = 1'b1;
            com_cnt_nxt = '0;
          end else begin
            state_nxt   = LOCK;
            com_cnt_nxt = COM_CNT_W'(1);
          end
        end
      end

      LOCK: begin
        if (boundary) begin
          if (is_com) begin
            if (com_cnt + 1'b1 == COM_LAST) begin
              state_nxt   = ACTIVE;
              active_nxt  = 1'b1;
              com_cnt_nxt = '0;
            end else begin
              com_cnt_nxt = com_cnt + 1'b1;
            end
          end else begin
            state_nxt   = SEARCH;
            com_cnt_nxt = '0;
          end
        end
      end

      ACTIVE: begin
        if (boundary) begin
          if (is_com || is_idl) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt  = nsr;
            valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_S2P) begin
    if (reset) begin
      state          <= SEARCH;
      sr             <= '0;
      bit_cnt        <= '0;
      com_cnt        <= '0;
      data_out_S2P   <= '0;
      valid_out_S2P  <= 1'b0;
      active_out_S2P <= 1'b0;
    end else begin
      state          <= state_nxt;
      sr             <= nsr[WIDTH-2:0];
      bit_cnt        <= bit_cnt_nxt;
      com_cnt        <= com_cnt_nxt;
      data_out_S2P   <= data_nxt;
      valid_out_S2P  <= valid_nxt;
      active_out_S2P <= active_nxt;
    end
  end

endmodule : rx_serial_to_parallel

// File: tb/tb_rx_serial_to_parallel.sv
// Bench for rx_serial_to_parallel: directed lock/data/reset scenarios followed by random
// word traffic, with a bit-history reference model feeding a scoreboard queue.
module tb_rx_serial_to_parallel;

  localparam logic [31:0] COM_W = 32'hBCBCBCBC;
  localparam logic [31:0] IDL_W = 32'h7C7C7C7C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_in = 1'b0;
  logic [31:0] d4, d1;
  logic        v4, v1, a4, a1;

  always #5 clk = ~clk;

  rx_serial_to_parallel #(.NUM_COM(4)) dut4 (
    .clk_S2P        (clk),
    .reset          (reset),
    .data_in_S2P    (data_in),
    .data_out_S2P   (d4),
    .valid_out_S2P  (v4),
    .active_out_S2P (a4)
  );

  rx_serial_to_parallel #(.NUM_COM(1)) dut1 (
    .clk_S2P        (clk),
    .reset          (reset),
    .data_in_S2P    (data_in),
    .data_out_S2P   (d1),
    .valid_out_S2P  (v1),
    .active_out_S2P (a1)
  );

  // Reference model: bit index n, phase origin of the first COM match, words on
  // every 32-bit multiple from that origin.
  typedef struct {
    logic [31:0] hist;
    bit          aligned;
    longint      origin;
    int          coms;
    bit          active;
    logic [31:0] dout;
    bit          vout;
    longint      n;
  } mdl_t;

  typedef struct {
    logic [31:0] d4;
    bit          v4;
    bit          a4;
    logic [31:0] d1;
    bit          v1;
    bit          a1;
  } exp_t;

  mdl_t m4, m1;
  exp_t expq[$];
  int   total  = 0;
  int   passed = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.hist = '0; r.aligned = 0; r.origin = 0; r.coms = 0;
    r.active = 0; r.dout = '0; r.vout = 0; r.n = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit b, input bit rst, input int num_com);
    mdl_t r;
    if (rst) return mdl_reset();
    r = m;
    r.n = m.n + 1;
    r.hist = {m.hist[30:0], b};
    if (!m.aligned) begin
      if (r.hist == COM_W) begin
        r.aligned = 1;
        r.origin = r.n;
        r.coms = 1;
        if (num_com == 1) r.active = 1;
      end
    end else if ((r.n - r.origin) % 32 == 0) begin
      if (!m.active) begin
        if (r.hist == COM_W) begin
          r.coms = r.coms + 1;
          if (r.coms == num_com) r.active = 1;
        end else begin
          r.aligned = 0;
          r.coms = 0;
        end
      end else if (r.hist == COM_W || r.hist == IDL_W) begin
        r.vout = 0;
      end else begin
        r.dout = r.hist;
        r.vout = 1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic drive(input bit b, input bit rst);
    exp_t e;
    @(negedge clk);
    data_in = b;
    reset   = rst;
    m4 = mstep(m4, b, rst, 4);
    m1 = mstep(m1, b, rst, 1);
    e.d4 = m4.dout; e.v4 = m4.vout; e.a4 = m4.active;
    e.d1 = m1.dout; e.v1 = m1.vout; e.a1 = m1.active;
    expq.push_back(e);
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo, input bit rst);
    for (int i = hi; i >= lo; i--) drive(w[i], rst);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 31, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge the DUTs present outputs, compare against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("mon_data4",   d4,         e.d4);
        chk("mon_valid4",  32'(v4),    32'(e.v4));
        chk("mon_active4", 32'(a4),    32'(e.a4));
        chk("mon_data1",   d1,         e.d1);
        chk("mon_valid1",  32'(v1),    32'(e.v1));
        chk("mon_active1", 32'(a1),    32'(e.a1));
      end
    end
  end

  initial begin
    int unsigned k, nj;
    logic [31:0] w;
    m4 = mdl_reset();
    m1 = mdl_reset();

    // Reset with random serial input.
    for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1);
    settle();
    chk("rst_data",   d4,        32'h0);
    chk("rst_valid",  32'(v4),   32'h0);
    chk("rst_active", 32'(a4),   32'h0);

    // Junk bit, then four COM words.
    drive(1'($urandom_range(0, 1)), 0);
    send_word(COM_W);
    settle();
    chk("num1_active_after_1com", 32'(a1), 32'h1);
    chk("lock_active_after_1com", 32'(a4), 32'h0);
    send_word(COM_W);
    send_word(COM_W);
    settle();
    chk("lock_active_after_3com", 32'(a4), 32'h0);
    send_word(COM_W);
    settle();
    chk("lock_active_after_4com", 32'(a4), 32'h1);
    chk("lock_valid_after_4com",  32'(v4), 32'h0);

    // Data after lock.
    send_word(IDL_W);
    settle();
    chk("idle_valid", 32'(v4), 32'h0);
    send_word(32'hDEADBEEF);
    settle();
    chk("word1_data",  d4,      32'hDEADBEEF);
    chk("word1_valid", 32'(v4), 32'h1);
    w = 32'h12345678;
    send_bits(w, 31, 16, 0);
    settle();
    chk("word1_hold_data",  d4,      32'hDEADBEEF);
    chk("word1_hold_valid", 32'(v4), 32'h1);
    send_bits(w, 15, 0, 0);
    settle();
    chk("word2_data",  d4,      32'h12345678);
    chk("word2_valid", 32'(v4), 32'h1);

    // Broken lock, then a clean relock.
    drive(1'b0, 1);
    send_word(COM_W);
    send_word(COM_W);
    send_word(32'h00000000);
    settle();
    chk("broken_active", 32'(a4), 32'h0);
    repeat (4) send_word(COM_W);
    settle();
    chk("relock_active", 32'(a4), 32'h1);
    send_word(32'hCAFEF00D);
    settle();
    chk("relock_data", d4, 32'hCAFEF00D);

    // Reset in the middle of an ACTIVE word.
    w = 32'hA5A5A5A5;
    send_bits(w, 31, 15, 0);
    drive(w[14], 1);
    settle();
    chk("midrst_data",   d4,      32'h0);
    chk("midrst_valid",  32'(v4), 32'h0);
    chk("midrst_active", 32'(a4), 32'h0);
    send_bits(w, 13, 0, 0);
    send_word(32'h11223344);
    send_word(32'h55667788);
    settle();
    chk("midrst_no_valid", 32'(v4), 32'h0);
    repeat (4) send_word(COM_W);
    send_word(32'h0BADCAFE);
    settle();
    chk("midrst_relock_data", d4, 32'h0BADCAFE);

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: send_word($urandom);
        4: send_word(COM_W);
        5: send_word(IDL_W);
        6: begin
          nj = $urandom_range(1, 7);
          for (int j = 0; j < int'(nj); j++) drive(1'($urandom_range(0, 1)), 0);
        end
        7: begin
          nj = $urandom_range(1, 3);
          for (int j = 0; j < int'(nj); j++) drive(1'($urandom_range(0, 1)), 1);
        end
        default: repeat (4) send_word(COM_W);
      endcase
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_rx_serial_to_parallel
